// File: rtl/line_sequencer.sv
// line_sequencer
//
// Sequences the per-line renderers (layer 0, layer 1, sprites) for one
// display line at a time and flips the double-buffered line buffer banks.
//
// A render request (line_render_start) is accepted in any state. On accept
// the block latches the line index, toggles the write bank and snapshots the
// stage enables into a shadow copy. That shadow copy governs the whole line.
// Stages then run in the order L0 -> L1 -> SPR, skipping any stage that is
// disabled. If a request arrives while a line is still in progress, the block
// issues abort and overrun and restarts with the new line.
//
// Build option:
//   LINE_SEQ_STATS_EN  when defined, overrun_count is a saturating 8-bit
//                      count of overrun pulses. When undefined it is
//                      constant 0 and the counter is not built.
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous, active-high reset
//   line_render_start   one-cycle render request from the composer
//   line_idx[8:0]       scaled line number accompanying the request
//   layer0_enabled      stage enable for layer 0
//   layer1_enabled      stage enable for layer 1
//   sprites_enabled     stage enable for sprites
//   l0_done             renderer completion pulse for layer 0
//   l1_done             renderer completion pulse for layer 1
//   spr_done            renderer completion pulse for sprites
//   l0_start            registered start pulse for layer 0
//   l1_start            registered start pulse for layer 1
//   spr_start           registered start pulse for sprites
//   abort               registered pulse that stops every renderer
//   render_line_idx     line index latched for the renderers
//   lb_wrbank           line-buffer bank being rendered into
//   lb_rdbank           line-buffer bank being displayed (~lb_wrbank)
//   busy                high whenever a line is in progress
//   overrun             registered pulse when a request arrives while busy
//   overrun_count[7:0]  saturating overrun counter (see build option)

module line_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic       line_render_start,
    input  logic [8:0] line_idx,
    input  logic       layer0_enabled,
    input  logic       layer1_enabled,
    input  logic       sprites_enabled,
    input  logic       l0_done,
    input  logic       l1_done,
    input  logic       spr_done,
    output logic       l0_start,
    output logic       l1_start,
    output logic       spr_start,
    output logic       abort,
    output logic [8:0] render_line_idx,
    output logic       lb_wrbank,
    output logic       lb_rdbank,
    output logic       busy,
    output logic       overrun,
    output logic [7:0] overrun_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L0   = 2'd1,
        L1   = 2'd2,
        SPR  = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] shadow_en;
    logic [2:0] live_en;
    logic       done_honoured;
    logic       enter_stage;
    logic [2:0] start_next;

    // Enable vectors are packed {sprites, layer1, layer0}.
    assign live_en = {sprites_enabled, layer1_enabled, layer0_enabled};

    // First enabled stage in pipeline order; IDLE when nothing is enabled.
    function automatic state_t first_stage(input logic [2:0] en);
        if (en[0]) begin
            return L0;
        end else if (en[1]) begin
            return L1;
        end else if (en[2]) begin
            return SPR;
        end
        return IDLE;
    endfunction

    assign busy      = (state != IDLE);
    assign lb_rdbank = ~lb_wrbank;

    // Next-state logic. A done pulse counts only in its own stage and never
    // in the cycle that stage's start is still high, which filters stray or
    // early completions. A new request overrides any done in the same cycle.
    // Following stages are chosen from the shadow enables so that enable
    // changes in the middle of a line do not disturb it.
    always_comb begin
        state_next    = state;
        done_honoured = 1'b0;
        enter_stage   = 1'b0;
        start_next    = 3'b000;

        case (state)
            L0:      done_honoured = l0_done && !l0_start;
            L1:      done_honoured = l1_done && !l1_start;
            SPR:     done_honoured = spr_done && !spr_start;
            default: done_honoured = 1'b0;
        endcase

        if (line_render_start) begin
            state_next = first_stage(live_en);
        end else if (done_honoured) begin
            case (state)
                L0:      state_next = first_stage({shadow_en[2:1], 1'b0});
                L1:      state_next = first_stage({shadow_en[2], 2'b00});
                default: state_next = IDLE;
            endcase
        end

        enter_stage = line_render_start || done_honoured;

        if (enter_stage) begin
            case (state_next)
                L0:      start_next = 3'b001;
                L1:      start_next = 3'b010;
                SPR:     start_next = 3'b100;
                default: start_next = 3'b000;
            endcase
        end
    end

    // State, latched line context and the registered one-cycle pulses.
    // Reset drops the line silently: abort is cleared, never pulsed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            shadow_en       <= 3'b000;
            render_line_idx <= 9'd0;
            lb_wrbank       <= 1'b0;
            l0_start        <= 1'b0;
            l1_start        <= 1'b0;
            spr_start       <= 1'b0;
            abort           <= 1'b0;
            overrun         <= 1'b0;
        end else begin
            state     <= state_next;
            l0_start  <= start_next[0];
            l1_start  <= start_next[1];
            spr_start <= start_next[2];
            abort     <= line_render_start && busy;
            overrun   <= line_render_start && busy;
            if (line_render_start) begin
                render_line_idx <= line_idx;
                lb_wrbank       <= ~lb_wrbank;
                shadow_en       <= live_en;
            end
        end
    end

`ifdef LINE_SEQ_STATS_EN
    // Counts on the same edge that raises overrun, so the count and the
    // pulse become visible together. Holds at 255 instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun_count <= 8'd0;
        end else if (line_render_start && busy && (overrun_count != 8'hFF)) begin
            overrun_count <= overrun_count + 8'd1;
        end
    end
`else
    assign overrun_count = 8'd0;
`endif

endmodule

// File: doc/line_sequencer.md
LINE_SEQUENCER -- requirements
Module: line_sequencer

Interface
REQ-001 clk  input  1  system clock; all state changes on its rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 line_render_start  input  1  one-cycle pulse from the composer requesting a render of the next line.
REQ-004 line_idx  input  9  scaled line number that goes with line_render_start.
REQ-005 layer0_enabled, layer1_enabled, sprites_enabled  input  1 each  stage enables.
REQ-006 l0_done, l1_done, spr_done  input  1 each  renderer completion pulses.
REQ-007 l0_start, l1_start, spr_start  output  1 each  registered one-cycle renderer start pulses.
REQ-008 abort  output  1  registered one-cycle pulse; tells every renderer to stop its current line.
REQ-009 render_line_idx  output  9  line index latched for the renderers.
REQ-010 lb_wrbank  output  1  line-buffer bank being rendered into; lb_rdbank output 1 is always ~lb_wrbank (bank being displayed).
REQ-011 busy  output  1  high whenever state is not IDLE.
REQ-012 overrun  output  1  registered one-cycle pulse when a render request arrives while busy.
REQ-013 overrun_count  output  8  saturating overrun counter (see Configuration).

Function
REQ-014 States SHALL be IDLE, L0, L1, SPR; registered state, one-hot or binary.
REQ-015 Accept = line_render_start high in any state; in that cycle the block SHALL:
- latch line_idx into render_line_idx;
- toggle lb_wrbank;
- latch the three enables into a per-line shadow.
REQ-016 On accept, the next state SHALL be the first enabled stage in the order L0, L1, SPR, or IDLE if no stage is enabled.
REQ-017 Entering a stage SHALL assert its start pulse in the first cycle of that stage only, i.e. one cycle after the accept or after the previous stage's done.
REQ-018 A stage's done input SHALL be honoured only while in that stage and not in the cycle its start is asserted; all other done pulses SHALL be ignored.
REQ-019 On an honoured done, the block SHALL advance to the next shadow-enabled stage after the current one, else to IDLE.
REQ-020 Shadow enables SHALL govern the whole line; enable changes mid-line SHALL take effect at the next accept.
REQ-021 Accept while busy:
- assert overrun and abort in the next cycle;
- discard the current stage;
- restart at the first enabled stage per REQ-016, with the start pulse in the same cycle as abort.
REQ-022 A done arriving in the same cycle as an accept SHALL be ignored; the accept wins.
REQ-023 With all stages disabled, accept SHALL still toggle lb_wrbank and latch render_line_idx; busy stays low and no start pulse is issued.
REQ-024 Latency, assuming every renderer returns done D cycles after its start: line complete (busy low) 3*(D+1)+1 cycles after accept with all stages enabled.

Reset
REQ-025 During rst, outputs SHALL hold these values: state IDLE, all starts/abort/overrun 0, busy 0, render_line_idx 0, lb_wrbank 0 (lb_rdbank 1), overrun_count 0, shadow enables 0.
REQ-026 Reset asserted mid-line SHALL abandon the line without issuing abort.

Configuration
REQ-027 Macro LINE_SEQ_STATS_EN.
- Defined: overrun_count increments by 1 on each overrun pulse and saturates at 255.
- Undefined: overrun_count is constant 0 and the counter logic is absent.
- The overrun pulse exists in both builds.

Verification
REQ-028 All enabled, start with line_idx=5, each done 10 cycles after its start -> l0_start, l1_start, spr_start in order; render_line_idx=5; lb_wrbank 0->1; busy low 34 cycles after accept.
REQ-029 Only sprites enabled -> the cycle after accept, spr_start is 1 and l0_start/l1_start stay 0; busy drops the cycle after spr_done.
REQ-030 Second start while in L1, line_idx=6 -> overrun and abort next cycle together with l0_start; render_line_idx=6; lb_wrbank toggles again; overrun_count=1 (LINE_SEQ_STATS_EN).
REQ-031 Spurious l1_done during L0, and l0_done in the same cycle as l0_start -> both ignored; state stays L0.
REQ-032 300 overruns with LINE_SEQ_STATS_EN -> overrun_count=255; same test without the macro -> overrun_count=0.
REQ-033 rst asserted in SPR -> all outputs at REQ-025 values immediately, with no abort pulse; a fresh start afterwards sequences normally.
